// File: rtl/bp_cce_mem_arbiter.sv
`timescale 1ns/1ps
// bp_cce_mem_arbiter: shares one mem command/response channel pair among num_cce_p CCEs.
// Commands are granted round-robin; an in-order ID FIFO remembers the issuing CCE so
// each memory response is steered back to its owner. Both channels pass through with
// zero latency; only the round-robin pointer, FIFO state and error flag are registered.
module bp_cce_mem_arbiter #(
  parameter int unsigned num_cce_p         = 2,
  parameter int unsigned cmd_width_p       = 64,
  parameter int unsigned resp_width_p      = 64,
  parameter int unsigned max_outstanding_p = 4,
  localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_cce_p*cmd_width_p-1:0] cce_cmd_i,
  input  logic [num_cce_p-1:0]             cce_cmd_v_i,
  output logic [num_cce_p-1:0]             cce_cmd_ready_o,
  output logic [cmd_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_i,
  input  logic [resp_width_p-1:0]          mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [resp_width_p-1:0]          cce_resp_o,
  output logic [num_cce_p-1:0]             cce_resp_v_o,
  input  logic [num_cce_p-1:0]             cce_resp_yumi_i,
  output logic [cnt_width_lp-1:0]          outstanding_o,
  output logic                             err_o
);

  localparam int unsigned id_width_lp  = (num_cce_p > 1) ? $clog2(num_cce_p) : 1;
  localparam int unsigned ptr_width_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

  localparam logic [cnt_width_lp-1:0] max_cnt_lp  = cnt_width_lp'(max_outstanding_p);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);
  localparam logic [id_width_lp-1:0]  last_id_lp  = id_width_lp'(num_cce_p - 1);

  logic [id_width_lp-1:0]  rr_ptr;
  logic [cnt_width_lp-1:0] count;
  logic [ptr_width_lp-1:0] wr_ptr;
  logic [ptr_width_lp-1:0] rd_ptr;
  logic [id_width_lp-1:0]  id_mem [max_outstanding_p];

  logic                    grant_v;
  logic [id_width_lp-1:0]  grant_id;
  logic [num_cce_p-1:0]    grant_oh;
  logic [id_width_lp-1:0]  head_id;
  logic [num_cce_p-1:0]    head_oh;
  int unsigned             cand;

  logic can_issue;
  logic fifo_empty;
  logic resp_route;
  logic push;
  logic pop;

  assign can_issue  = (count < max_cnt_lp);
  assign fifo_empty = (count == '0);
  assign head_id    = id_mem[rd_ptr];

  // Round-robin search starting at rr_ptr, wrapping modulo num_cce_p.
  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    grant_oh = '0;
    cand     = 0;
    for (int unsigned k = 0; k < num_cce_p; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= num_cce_p) cand = cand - num_cce_p;
      if (!grant_v && cce_cmd_v_i[id_width_lp'(cand)]) begin
        grant_v  = 1'b1;
        grant_id = id_width_lp'(cand);
      end
    end
    grant_oh[grant_id] = grant_v;
  end

  // One-hot decode of the owner of the oldest outstanding command.
  always_comb begin
    head_oh          = '0;
    head_oh[head_id] = 1'b1;
  end

  // Command channel: granted payload forwarded, ready only to the granted CCE.
  always_comb begin
    mem_cmd_o       = grant_v ? cce_cmd_i[32'(grant_id)*cmd_width_p +: cmd_width_p] : '0;
    mem_cmd_v_o     = reset_n_i & can_issue & grant_v;
    cce_cmd_ready_o = (reset_n_i & can_issue & mem_cmd_ready_i) ? grant_oh : '0;
  end

  // Response channel: broadcast payload, valid only to the FIFO head owner.
  always_comb begin
    resp_route      = reset_n_i & ~fifo_empty & mem_resp_v_i;
    cce_resp_o      = mem_resp_i;
    cce_resp_v_o    = resp_route ? head_oh : '0;
    mem_resp_yumi_o = resp_route & cce_resp_yumi_i[head_id];
  end

  assign push          = mem_cmd_v_o & mem_cmd_ready_i;
  assign pop           = mem_resp_yumi_o;
  assign outstanding_o = count;

  // Arbitration pointer, FIFO pointers, outstanding count and sticky orphan flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) begin
        rr_ptr <= (grant_id == last_id_lp) ? '0 : grant_id + id_width_lp'(1);
        wr_ptr <= (wr_ptr == last_ptr_lp) ? '0 : wr_ptr + ptr_width_lp'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == last_ptr_lp) ? '0 : rd_ptr + ptr_width_lp'(1);
      end
      if (push && !pop) begin
        count <= count + cnt_width_lp'(1);
      end else if (pop && !push) begin
        count <= count - cnt_width_lp'(1);
      end
      if (mem_resp_v_i && fifo_empty) begin
        err_o <= 1'b1;
      end
    end
  end

  // ID storage; contents are only meaningful between the FIFO pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem[wr_ptr] <= grant_id;
    end
  end

endmodule
